// File: rtl/class_decision.sv
// class_decision: accumulates NUM_CLASSES signed scores per frame and emits
// a one-hot class decision per frame on a valid/ready/last stream. Class 0
// (wake) only wins when it clears WAKE_THRESHOLD and is at least as large as
// every other class score.
module class_decision #(
  parameter int NUM_CLASSES    = 3,
  parameter int SCORE_BW       = 8,
  parameter int WAKE_THRESHOLD = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic signed [SCORE_BW-1:0] data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [NUM_CLASSES-1:0]     data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       err_o
);

  localparam int CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [CNT_W-1:0]           LAST_IDX  = CNT_W'(NUM_CLASSES - 1);
  localparam logic signed [SCORE_BW-1:0] THRESHOLD = SCORE_BW'(WAKE_THRESHOLD);
  localparam logic [NUM_CLASSES-1:0]     WAKE_HOT  = NUM_CLASSES'(1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [SCORE_BW-1:0]  score0_q, score0_d;
  logic signed [SCORE_BW-1:0]  best_rest_q, best_rest_d;
  logic [CNT_W-1:0]            best_idx_q, best_idx_d;
  logic [NUM_CLASSES-1:0]      data_q, decision;
  logic                        err_q;

  logic in_xfer, out_xfer, at_last_idx, ending, frame_err;

  // Handshake and frame-boundary qualifiers.
  assign valid_o     = (state_q == HOLD);
  assign last_o      = valid_o;
  assign data_o      = data_q;
  assign err_o       = err_q;
  assign ready_o     = ~valid_o | ready_i;
  assign in_xfer     = valid_i & ready_o;
  assign out_xfer    = valid_o & ready_i;
  assign at_last_idx = (cnt_q == LAST_IDX);
  assign ending      = in_xfer & (last_i | at_last_idx);
  assign frame_err   = in_xfer & (last_i ? ~at_last_idx : at_last_idx);

  // Score tracking and the decision, both including the beat being accepted.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    cnt_d       = cnt_q;
    score0_d    = score0_q;
    best_rest_d = best_rest_q;
    best_idx_d  = best_idx_q;
    decision    = '0;
    if (in_xfer) begin
      if (cnt_q == '0) begin
        score0_d = data_i;
      end else if ((cnt_q == CNT_W'(1)) || (data_i > best_rest_q)) begin
        // Strictly greater keeps ties on the lowest index.
        best_rest_d = data_i;
        best_idx_d  = cnt_q;
      end
      cnt_d = ending ? '0 : cnt_q + CNT_W'(1);
    end
    if (cnt_q == '0) begin
      // Frame cut short on beat 0: only class 0 exists to be judged.
      decision = (data_i >= THRESHOLD) ? WAKE_HOT : '0;
    end else if ((score0_q >= THRESHOLD) && (score0_q >= best_rest_d)) begin
      decision = WAKE_HOT;
    end else begin
      decision = WAKE_HOT << best_idx_d;
    end
  end

  // Next-state logic: a decision is held until accepted, and a simultaneous
  // ending beat reloads it without a bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (ending) state_d = HOLD;
      HOLD:    if (out_xfer && !ending) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State, score and decision registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      score0_q    <= '0;
      best_rest_q <= '0;
      best_idx_q  <= '0;
      data_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score0_q    <= score0_d;
      best_rest_q <= best_rest_d;
      best_idx_q  <= best_idx_d;
      if (ending) begin
        data_q <= decision;
      end else if (out_xfer) begin
        data_q <= '0;
      end
    end
  end

  // Sticky frame-length error, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (frame_err) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_class_decision.sv
// Self-checking bench for class_decision: two instances (threshold 0 and 16)
// share one stimulus stream; a frame-level reference model predicts the
// handshake, decisions and the sticky error flag.
module tb_class_decision;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       last_i = 1'b0;
  logic       ready_i = 1'b0;

  logic         ready_a, valid_a, last_a, err_a;
  logic [N-1:0] data_a;
  logic         ready_b, valid_b, last_b, err_b;
  logic [N-1:0] data_b;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int           frame[$];
  logic         exp_valid = 1'b0;
  logic         exp_err = 1'b0;
  logic [N-1:0] exp_da = '0;
  logic [N-1:0] exp_db = '0;

  class_decision #(.NUM_CLASSES(N), .SCORE_BW(8), .WAKE_THRESHOLD(0)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_a), .data_o(data_a), .valid_o(valid_a),
    .last_o(last_a), .ready_i(ready_i), .err_o(err_a)
  );

  class_decision #(.NUM_CLASSES(N), .SCORE_BW(8), .WAKE_THRESHOLD(16)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_b), .data_o(data_b), .valid_o(valid_b),
    .last_o(last_b), .ready_i(ready_i), .err_o(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decision from the rules: wake class needs threshold and >= all others;
  // among classes 1.., the first maximum wins.
  function automatic logic [N-1:0] decide(input int s[$], input int th);
    int best;
    if (s.size() == 1) return (s[0] >= th) ? N'(1) : N'(0);
    best = 1;
    for (int i = 2; i < s.size(); i++) if (s[i] > s[best]) best = i;
    if (s[0] >= th && s[0] >= s[best]) return N'(1);
    return N'(1) << best;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid_a"}, 32'(valid_a), 32'(exp_valid));
    check({tag, ".valid_b"}, 32'(valid_b), 32'(exp_valid));
    check({tag, ".last_a"},  32'(last_a),  32'(exp_valid));
    check({tag, ".last_b"},  32'(last_b),  32'(exp_valid));
    check({tag, ".err_a"},   32'(err_a),   32'(exp_err));
    check({tag, ".err_b"},   32'(err_b),   32'(exp_err));
    if (exp_valid) begin
      check({tag, ".data_a"}, 32'(data_a), 32'(exp_da));
      check({tag, ".data_b"}, 32'(data_b), 32'(exp_db));
    end
  endtask

  // One clock cycle: drive, check ready, advance the model at the edge,
  // then check the registered outputs just after the edge.
  task automatic step(input string tag, input logic v, input logic l,
                      input logic [7:0] d, input logic r);
    logic exp_ready, in_x, out_x, ending;
    valid_i = v; last_i = l; data_i = d; ready_i = r;
    #1;
    exp_ready = !exp_valid || r;
    check({tag, ".ready_a"}, 32'(ready_a), 32'(exp_ready));
    check({tag, ".ready_b"}, 32'(ready_b), 32'(exp_ready));
    @(posedge clk);
    in_x   = v && exp_ready;
    out_x  = exp_valid && r;
    ending = 1'b0;
    if (in_x) begin
      frame.push_back(int'($signed(d)));
      if (l && frame.size() < N) exp_err = 1'b1;
      if (!l && frame.size() == N) exp_err = 1'b1;
      ending = l || (frame.size() == N);
    end
    if (out_x) exp_valid = 1'b0;
    if (ending) begin
      exp_valid = 1'b1;
      exp_da = decide(frame, 0);
      exp_db = decide(frame, 16);
      frame.delete();
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic frame3(input string tag, input int a, input int b, input int c);
    step(tag, 1'b1, 1'b0, 8'(a), 1'b1);
    step(tag, 1'b1, 1'b0, 8'(b), 1'b1);
    step(tag, 1'b1, 1'b1, 8'(c), 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    frame.delete();
    exp_valid = 1'b0; exp_err = 1'b0; exp_da = '0; exp_db = '0;
    check({tag, ".data_a"}, 32'(data_a), 32'd0);
    check({tag, ".data_b"}, 32'(data_b), 32'd0);
    check_outputs(tag);
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int sz;
    logic v, l, r;
    #2;
    apply_reset("reset");

    // Basic frames and tie-breaking.
    frame3("basic", 20, 5, -3);
    step("idle", 1'b0, 1'b0, 8'h00, 1'b1);
    frame3("tie_rest", -4, 10, 10);
    frame3("tie_wake", 7, 7, 1);
    // Threshold boundary for the threshold-16 instance.
    frame3("thr_below", 15, -128, -100);
    frame3("thr_equal", 16, -128, -100);
    step("drain", 1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure: decision held, next frame stalled, then released.
    step("bp", 1'b1, 1'b0, 8'(3), 1'b0);
    step("bp", 1'b1, 1'b0, 8'(9), 1'b0);
    step("bp", 1'b1, 1'b1, 8'(-1), 1'b0);
    step("bp_hold", 1'b1, 1'b0, 8'(40), 1'b0);
    step("bp_hold", 1'b1, 1'b0, 8'(40), 1'b0);
    step("bp_release", 1'b1, 1'b0, 8'(40), 1'b1);
    step("bp_next", 1'b1, 1'b0, 8'(2), 1'b1);
    step("bp_next", 1'b1, 1'b1, 8'(50), 1'b1);

    // Back-to-back frames at full rate.
    frame3("b2b", 1, 2, 3);
    frame3("b2b", 100, -5, 99);
    frame3("b2b", -50, -60, -70);
    step("drain", 1'b0, 1'b0, 8'h00, 1'b1);

    // Short frame: last on beat 1 raises the sticky error.
    step("short", 1'b1, 1'b0, 8'(30), 1'b1);
    step("short", 1'b1, 1'b1, 8'(2), 1'b1);
    step("short_sticky", 1'b0, 1'b0, 8'h00, 1'b1);
    step("short_sticky", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    step("mid", 1'b1, 1'b0, 8'(77), 1'b1);
    apply_reset("mid_reset");
    frame3("after_reset", -10, -20, 5);
    step("drain", 1'b0, 1'b0, 8'h00, 1'b1);

    // Single-beat frame and a missing-last frame.
    step("one_beat", 1'b1, 1'b1, 8'(16), 1'b1);
    step("no_last", 1'b1, 1'b0, 8'(-3), 1'b1);
    step("no_last", 1'b1, 1'b0, 8'(-9), 1'b1);
    step("no_last", 1'b1, 1'b0, 8'(-2), 1'b1);
    apply_reset("reset2");

    // Randomized traffic with gaps, backpressure and occasional bad lasts.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) apply_reset("rand_reset");
      sz = frame.size();
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 19) == 0) ? 1'($urandom_range(0, 1)) : (sz == N - 1);
      step("rand", v, l, 8'($urandom), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
